// File: rtl/fft_frame_sequencer_if.sv
// Stream-in, stream-out and FFT engine signal bundle for the frame sequencer.
// master: the sequencer side; slave: upstream, downstream and engine side.
interface fft_frame_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  // upstream sample stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  // downstream result stream
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_index;
  logic             out_last;
  // engine control and data
  logic             fft_en;
  logic             fft_valid;
  logic [WIDTH-1:0] fft_x0;
  logic [WIDTH-1:0] fft_x1;
  logic [WIDTH-1:0] fft_x2;
  logic [WIDTH-1:0] fft_x3;
  logic [WIDTH-1:0] fft_X0;
  logic [WIDTH-1:0] fft_X1;
  logic [WIDTH-1:0] fft_X2;
  logic [WIDTH-1:0] fft_X3;

  modport master (
    input  in_valid, in_data, out_ready, fft_valid,
           fft_X0, fft_X1, fft_X2, fft_X3,
    output in_ready, out_valid, out_data, out_index, out_last, fft_en,
           fft_x0, fft_x1, fft_x2, fft_x3
  );

  modport slave (
    output in_valid, in_data, out_ready, fft_valid,
           fft_X0, fft_X1, fft_X2, fft_X3,
    input  in_ready, out_valid, out_data, out_index, out_last, fft_en,
           fft_x0, fft_x1, fft_x2, fft_x3
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the 4-point FFT engine: load four samples, run the
// engine enable/valid handshake with enable release, unload four results.
// A watchdog aborts a frame whose engine never reports valid.
module fft_frame_sequencer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_frame_sequencer_if.master bus,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [7:0]            frame_count
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2,
    UNLOAD  = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       sample_idx;
  logic [1:0]       result_idx;
  logic [WIDTH-1:0] sample_buf [4];
  logic [WIDTH-1:0] result_buf [4];
  logic [CNT_W-1:0] timeout_cnt;
  logic             abort_flag;

  // Frame state machine with sample/result buffers, watchdog and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      sample_idx  <= 2'd0;
      result_idx  <= 2'd0;
      timeout_cnt <= '0;
      abort_flag  <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        sample_buf[i] <= '0;
        result_buf[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          // in_ready is high for the whole of LOAD, so in_valid is the handshake
          if (bus.in_valid) begin
            sample_buf[sample_idx] <= bus.in_data;
            if (sample_idx == 2'd3) begin
              sample_idx <= 2'd0;
              state      <= RUN;
            end else begin
              sample_idx <= sample_idx + 2'd1;
            end
          end
        end

        RUN: begin
          // valid takes priority over a watchdog expiry on the same cycle
          if (bus.fft_valid) begin
            result_buf[0] <= bus.fft_X0;
            result_buf[1] <= bus.fft_X1;
            result_buf[2] <= bus.fft_X2;
            result_buf[3] <= bus.fft_X3;
            timeout_cnt   <= '0;
            state         <= RELEASE;
          end else if (timeout_cnt == CNT_LIMIT) begin
            timeout_err <= 1'b1;
            abort_flag  <= 1'b1;
            timeout_cnt <= '0;
            state       <= RELEASE;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          // hold enable low until the engine has dropped valid
          if (!bus.fft_valid) begin
            abort_flag <= 1'b0;
            state      <= abort_flag ? LOAD : UNLOAD;
          end
        end

        UNLOAD: begin
          if (bus.out_ready) begin
            if (result_idx == 2'd3) begin
              result_idx  <= 2'd0;
              frame_count <= frame_count + 8'd1;
              state       <= LOAD;
            end else begin
              result_idx <= result_idx + 2'd1;
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

  // Control strobes decoded from the state register, forced low during reset
  always_comb begin
    bus.in_ready  = (state == LOAD)   && !rst;
    bus.fft_en    = (state == RUN)    && !rst;
    bus.out_valid = (state == UNLOAD) && !rst;
    bus.out_last  = (state == UNLOAD) && (result_idx == 2'd3);
    busy          = !((state == LOAD) && (sample_idx == 2'd0));
  end

  // Data paths: engine inputs track the sample buffer, output tracks the result index
  always_comb begin
    bus.fft_x0    = sample_buf[0];
    bus.fft_x1    = sample_buf[1];
    bus.fft_x2    = sample_buf[2];
    bus.fft_x3    = sample_buf[3];
    bus.out_data  = result_buf[result_idx];
    bus.out_index = result_idx;
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed and randomized bench for fft_frame_sequencer with a behavioural
// engine model (configurable latency, valid hold after enable, or no response).
module tb_fft_frame_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 64;

  typedef logic [3:0][W-1:0] frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic       timeout_err;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;

  fft_frame_sequencer_if #(.WIDTH(W)) bus ();

  fft_frame_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // engine model configuration
  int     eng_lat   = 5;
  int     eng_hold  = 0;
  bit     eng_never = 1'b0;
  frame_t eng_res   = '0;
  int     run_cnt   = 0;
  int     hold_left = 0;

  // Engine model: valid after eng_lat enabled cycles, held eng_hold cycles past enable
  always @(posedge clk) begin
    if (bus.fft_en) run_cnt <= run_cnt + 1;
    else if (hold_left == 0) run_cnt <= 0;
    if (bus.fft_en && bus.fft_valid) hold_left <= eng_hold;
    else if (hold_left != 0) hold_left <= hold_left - 1;
  end

  assign bus.fft_valid = !eng_never && ((bus.fft_en && (run_cnt >= eng_lat - 1)) || (hold_left != 0));
  assign bus.fft_X0 = eng_res[0];
  assign bus.fft_X1 = eng_res[1];
  assign bus.fft_X2 = eng_res[2];
  assign bus.fft_X3 = eng_res[3];

  // Watch for enable rising while the engine was still reporting valid
  int   en_rise_viol = 0;
  logic prev_en      = 1'b0;
  logic prev_valid   = 1'b0;
  always @(negedge clk) begin
    if (bus.fft_en && !prev_en && prev_valid) en_rise_viol++;
    prev_en    = bus.fft_en;
    prev_valid = bus.fft_valid;
  end

  initial begin
    #2ms;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t rnd_frame();
    frame_t f;
    for (int i = 0; i < 4; i++) f[i] = W'($urandom);
    return f;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst fft_en", 64'(bus.fft_en), 64'(0));
    chk("rst out_valid", 64'(bus.out_valid), 64'(0));
    rst = 1'b0;
    step();
  endtask

  // Feed four samples, gap idle cycles before each
  task automatic load(input frame_t x, input int gap);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = x[i];
      chk("load in_ready", 64'(bus.in_ready), 64'(1));
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = W'($urandom);
    end
    chk("in_ready drop", 64'(bus.in_ready), 64'(0));
    chk("fft_en rise", 64'(bus.fft_en), 64'(1));
  endtask

  // Measure RUN (fft_en high) and RELEASE lengths and the state entered afterwards
  task automatic run_phase(input frame_t x, input int exp_en, input int exp_rel, input bit exp_abort);
    int n;
    int r;
    n = 0;
    while (bus.fft_en && n < 300) begin
      chk("fft_x hold", 64'({bus.fft_x3, bus.fft_x2, bus.fft_x1, bus.fft_x0}), 64'(x));
      chk("run in_ready", 64'(bus.in_ready), 64'(0));
      step();
      n++;
    end
    chk("fft_en cycles", 64'(n), 64'(exp_en));
    r = 0;
    while (!bus.out_valid && !bus.in_ready && r < 300) begin
      chk("release fft_en", 64'(bus.fft_en), 64'(0));
      step();
      r++;
    end
    chk("release cycles", 64'(r), 64'(exp_rel));
    chk("exit to load", 64'(bus.in_ready), 64'(exp_abort));
    chk("exit to unload", 64'(bus.out_valid), 64'(!exp_abort));
  endtask

  // Drain four results with a cyclic out_ready pattern
  task automatic unload(input frame_t exp, input bit [15:0] pat, input int plen);
    int k;
    int t;
    bit stalled;
    logic [W+2:0] held;
    k = 0;
    t = 0;
    stalled = 1'b0;
    held = '0;
    while (k < 4 && t < 200) begin
      bus.out_ready = pat[t % plen];
      chk("unload out_valid", 64'(bus.out_valid), 64'(1));
      if (stalled) chk("stall stable", 64'({bus.out_data, bus.out_index, bus.out_last}), 64'(held));
      if (bus.out_ready) begin
        chk("out_data", 64'(bus.out_data), 64'(exp[k]));
        chk("out_index", 64'(bus.out_index), 64'(k));
        chk("out_last", 64'(bus.out_last), 64'(k == 3));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = {bus.out_data, bus.out_index, bus.out_last};
      end
      step();
      t++;
    end
    bus.out_ready = 1'b0;
    chk("unload count", 64'(k), 64'(4));
    chk("out_valid after last", 64'(bus.out_valid), 64'(0));
  endtask

  // Main directed sequence
  initial begin
    frame_t     x;
    frame_t     res;
    logic [7:0] exp_fc;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // basic frame
    do_reset();
    exp_fc = 8'd0;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset timeout_err", 64'(timeout_err), 64'(0));
    chk("reset frame_count", 64'(frame_count), 64'(0));
    chk("reset in_ready", 64'(bus.in_ready), 64'(1));
    x   = {16'h7FFF, 16'd7, 16'hFFEC, 16'd100};
    res = {16'h8000, 16'hFFDF, 16'd22, 16'd11};
    eng_res = res; eng_lat = 5; eng_hold = 0; eng_never = 1'b0;
    load(x, 0);
    chk("busy in run", 64'(busy), 64'(1));
    run_phase(x, 5, 1, 1'b0);
    unload(res, 16'h0001, 1);
    exp_fc++;
    chk("basic frame_count", 64'(frame_count), 64'(exp_fc));

    // backpressure with sparse input
    x = rnd_frame(); res = rnd_frame();
    eng_res = res; eng_lat = int'($urandom_range(2, 8));
    load(x, 2);
    run_phase(x, eng_lat, 1, 1'b0);
    unload(res, 16'b1101001, 7);
    exp_fc++;
    chk("bp frame_count", 64'(frame_count), 64'(exp_fc));

    // engine holds valid after enable drops
    x = rnd_frame(); res = rnd_frame();
    eng_res = res; eng_lat = 4; eng_hold = 2;
    load(x, 0);
    run_phase(x, 4, 3, 1'b0);
    unload(res, 16'h0001, 1);
    exp_fc++;
    eng_hold = 0;

    // valid on the final watchdog cycle wins
    x = rnd_frame(); res = rnd_frame();
    eng_res = res; eng_lat = TO;
    load(x, 0);
    run_phase(x, TO, 1, 1'b0);
    chk("boundary no timeout", 64'(timeout_err), 64'(0));
    unload(res, 16'h0001, 1);
    exp_fc++;

    // watchdog abort, then a normal frame
    x = rnd_frame();
    eng_never = 1'b1;
    load(x, 0);
    run_phase(x, TO, 1, 1'b1);
    chk("timeout_err set", 64'(timeout_err), 64'(1));
    chk("timeout frame_count", 64'(frame_count), 64'(exp_fc));
    eng_never = 1'b0;
    x = rnd_frame(); res = rnd_frame();
    eng_res = res; eng_lat = 3;
    load(x, 1);
    run_phase(x, 3, 1, 1'b0);
    unload(res, 16'h0001, 1);
    exp_fc++;
    chk("timeout_err sticky", 64'(timeout_err), 64'(1));
    chk("post-timeout frame_count", 64'(frame_count), 64'(exp_fc));

    // reset during RUN
    x = rnd_frame();
    eng_lat = 30;
    load(x, 0);
    step(); step(); step();
    chk("mid-run fft_en", 64'(bus.fft_en), 64'(1));
    rst = 1'b1;
    step();
    chk("rst-run fft_en", 64'(bus.fft_en), 64'(0));
    chk("rst-run out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst-run timeout_err", 64'(timeout_err), 64'(0));
    chk("rst-run frame_count", 64'(frame_count), 64'(0));
    rst = 1'b0;
    step();
    exp_fc = 8'd0;

    // reset during UNLOAD
    x = rnd_frame(); res = rnd_frame();
    eng_res = res; eng_lat = 2;
    load(x, 0);
    run_phase(x, 2, 1, 1'b0);
    bus.out_ready = 1'b1;
    step(); step();
    chk("mid-unload out_valid", 64'(bus.out_valid), 64'(1));
    rst = 1'b1;
    bus.out_ready = 1'b0;
    step();
    chk("rst-unload fft_en", 64'(bus.fft_en), 64'(0));
    chk("rst-unload out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst-unload frame_count", 64'(frame_count), 64'(0));
    rst = 1'b0;
    step();
    chk("rst-unload busy", 64'(busy), 64'(0));

    // fresh frame after reset
    x = rnd_frame(); res = rnd_frame();
    eng_res = res; eng_lat = 6;
    load(x, 0);
    run_phase(x, 6, 1, 1'b0);
    unload(res, 16'h0001, 1);
    exp_fc++;
    chk("fresh frame_count", 64'(frame_count), 64'(exp_fc));

    // 256 back-to-back random frames wrap the counter
    do_reset();
    exp_fc = 8'd0;
    for (int f = 0; f < 256; f++) begin
      x = rnd_frame(); res = rnd_frame();
      eng_res  = res;
      eng_lat  = int'($urandom_range(1, 10));
      eng_hold = int'($urandom_range(0, 2));
      load(x, int'($urandom_range(0, 1)));
      run_phase(x, eng_lat, eng_hold + 1, 1'b0);
      unload(res, 16'h0001, 1);
      exp_fc++;
      if (f == 254) chk("frame_count 255", 64'(frame_count), 64'(255));
    end
    chk("frame_count wrap", 64'(frame_count), 64'(exp_fc));
    chk("frame_count zero", 64'(frame_count), 64'(0));
    chk("fft_en rise while valid", 64'(en_rise_viol), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
